tour_cmd_xlate: RTL

TOUR_CMD_XLATE -- requirements
Module: tour_cmd_xlate

---
 rtl/tour_cmd_xlate.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tour_cmd_xlate.sv
// rtl/tour_cmd_xlate.sv - knight-tour move to drive-command translator
// Owns the command path while a solved tour is replayed.
// Each one-hot knight move becomes a vertical command followed by a horizontal one.
// Each command is handed to cmd_proc with a clr_cmd_rdy/send_resp handshake.
// When no tour is active, UART commands pass straight through.
module tour_cmd_xlate (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        usurp,
  output logic        tour_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VERT  = 3'd1,
    HOLDV = 3'd2,
    HORZ  = 3'd3,
    HOLDH = 3'd4
  } state_t;

  localparam logic [4:0] LAST_MOVE = 5'd23;
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  state_t      state;
  logic [7:0]  move_q;
  logic        move_ok;
  logic        v_north;
  logic        v_two;
  logic        h_east;
  logic        h_two;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;

  // Decode the move into its vertical and horizontal legs.
  // The vertical leg uses the live memory word.
  // mv_indx is registered, so that word holds steady for the whole VERT state.
  // The horizontal leg uses the copy captured when VERT is left.
  always_comb begin
    move_ok  = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);
    v_north  = |(move & 8'b1000_0111);    // b0 b1 b2 b7: dy > 0
    v_two    = |(move & 8'b0011_0011);    // b0 b1 b4 b5: |dy| = 2
    h_east   = |(move_q & 8'b1110_0001);  // b0 b5 b6 b7: dx > 0
    h_two    = |(move_q & 8'b1100_1100);  // b2 b3 b6 b7: |dx| = 2
    vert_cmd = {4'h2, (v_north ? 8'h00 : 8'h7F), (v_two ? 4'd2 : 4'd1)};
    horz_cmd = {4'h3, (h_east ? 8'hBF : 8'h3F), (h_two ? 4'd2 : 4'd1)};
  end

  // Route the command path.
  // In IDLE the UART side passes straight through to cmd_proc.
  // In any other state the translated command is driven, and UART handshakes are blocked.
  // In VERT, cmd_rdy is withheld for an illegal move, so no command is issued.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = move_ok;
      end
      HOLDV: begin
        cmd = vert_cmd;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      HOLDH: begin
        cmd = horz_cmd;
      end
      default: begin
        cmd     = cmd_UART;
        cmd_rdy = 1'b0;
      end
    endcase
  end

  // Tour sequencer.
  // usurp, resp and tour_err are registered together with the next state.
  // Each state reacts only to the handshake it expects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mv_indx  <= 5'd0;
      move_q   <= 8'h00;
      usurp    <= 1'b0;
      resp     <= RESP_DONE;
      tour_err <= 1'b0;
    end else begin
      tour_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_tour) begin
            state   <= VERT;
            mv_indx <= 5'd0;
            usurp   <= 1'b1;
            resp    <= RESP_BUSY;
          end
        end
        VERT: begin
          if (!move_ok) begin
            state    <= IDLE;
            mv_indx  <= 5'd0;
            usurp    <= 1'b0;
            resp     <= RESP_DONE;
            tour_err <= 1'b1;
          end else if (clr_cmd_rdy) begin
            state  <= HOLDV;
            move_q <= move;
          end
        end
        HOLDV: begin
          if (send_resp) begin
            state <= HORZ;
          end
        end
        HORZ: begin
          if (clr_cmd_rdy) begin
            state <= HOLDH;
            resp  <= (mv_indx == LAST_MOVE) ? RESP_DONE : RESP_BUSY;
          end
        end
        HOLDH: begin
          if (send_resp) begin
            if (mv_indx == LAST_MOVE) begin
              state   <= IDLE;
              mv_indx <= 5'd0;
              usurp   <= 1'b0;
              resp    <= RESP_DONE;
            end else begin
              state   <= VERT;
              mv_indx <= mv_indx + 5'd1;
              resp    <= RESP_BUSY;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mv_indx <= 5'd0;
          usurp   <= 1'b0;
          resp    <= RESP_DONE;
        end
      endcase
    end
  end

endmodule
